// File: rtl/karatsuba8_pkg.sv
// Shared encodings and default widths for the 8x8 Karatsuba datapath.
package karatsuba8_pkg;

    localparam int KW  = 8;
    localparam int KH  = KW / 2;
    localparam int KPW = 2 * (KH + 1);

    typedef enum logic [1:0] {
        MUL_HH   = 2'b00,
        MUL_LL   = 2'b01,
        MUL_NONE = 2'b10,
        MUL_SUM  = 2'b11
    } mul_sel_e;

    typedef enum logic [2:0] {
        SS_P0  = 3'b000,
        SS_AB  = 3'b001,
        SS_CD  = 3'b010,
        SS_CE  = 3'b011,
        SS_SHB = 3'b100,
        SS_SHC = 3'b101,
        SS_Z0  = 3'b110,
        SS_Z1  = 3'b111
    } ss_sel_e;

endpackage

// File: rtl/karatsuba8_mul5.sv
// Half-operand selector feeding one (H+1)x(H+1) unsigned multiplier.
import karatsuba8_pkg::*;

module karatsuba8_mul5 #(
    parameter int W = KW
) (
    input  logic [W-1:0]           x,
    input  logic [W-1:0]           y,
    input  logic [1:0]             mul_sel,
    output logic [2*(W/2+1)-1:0]   p
);

    localparam int H  = W / 2;
    localparam int PW = 2 * (H + 1);

    logic [PW-1:0] ma;
    logic [PW-1:0] mb;

    always_comb begin
        ma = '0;
        mb = '0;
        unique case (mul_sel_e'(mul_sel))
            MUL_HH: begin
                ma = PW'(x[W-1:H]);
                mb = PW'(y[W-1:H]);
            end
            MUL_LL: begin
                ma = PW'(x[H-1:0]);
                mb = PW'(y[H-1:0]);
            end
            MUL_SUM: begin
                ma = PW'(x[W-1:H]) + PW'(x[H-1:0]);
                mb = PW'(y[W-1:H]) + PW'(y[H-1:0]);
            end
            MUL_NONE: ;
        endcase
    end

    // Both factors fit in H+1 bits, so the PW-bit product never truncates.
    assign p = ma * mb;

endmodule

// File: rtl/karatsuba8_fd.sv
// Karatsuba multiplier datapath: operand/partial registers, add/sub, capture.
// Optional KARATSUBA_FD_CHECK_EN adds a sticky err output for illegal words.
import karatsuba8_pkg::*;

module karatsuba8_fd #(
    parameter int W = KW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    input  logic             x_ld,
    input  logic             y_ld,
    input  logic             a_ld,
    input  logic             b_ld,
    input  logic             c_ld,
    input  logic             d_ld,
    input  logic             e_ld,
    input  logic             sub,
    input  logic             a_sel,
    input  logic             c_sel,
    input  logic             done,
    input  logic [1:0]       mul_sel,
    input  logic [2:0]       ss_sel,
    output logic [2*W-1:0]   product,
    output logic             valid
`ifdef KARATSUBA_FD_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int H  = W / 2;
    localparam int PW = 2 * (H + 1);
    localparam int XW = 2 * W;

    logic [W-1:0]  x_r;
    logic [W-1:0]  y_r;
    logic [XW-1:0] a_r;
    logic [PW-1:0] b_r;
    logic [PW-1:0] c_r;
    logic [PW-1:0] d_r;
    logic [PW-1:0] e_r;
    logic          done_q;

    logic [PW-1:0] p;
    logic [XW-1:0] op_a;
    logic [XW-1:0] op_b;
    logic [XW-1:0] r;

    karatsuba8_mul5 #(.W(W)) u_mul (
        .x       (x_r),
        .y       (y_r),
        .mul_sel (mul_sel),
        .p       (p)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (ss_sel_e'(ss_sel))
            SS_P0:  op_a = XW'(p);
            SS_AB: begin
                op_a = a_r;
                op_b = XW'(b_r);
            end
            SS_CD: begin
                op_a = XW'(c_r);
                op_b = XW'(d_r);
            end
            SS_CE: begin
                op_a = XW'(c_r);
                op_b = XW'(e_r);
            end
            SS_SHB: begin
                op_a = a_r << H;
                op_b = XW'(b_r);
            end
            SS_SHC: begin
                op_a = a_r << H;
                op_b = XW'(c_r);
            end
            SS_Z0, SS_Z1: ;
        endcase
    end

    assign r = sub ? op_a - op_b : op_a + op_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r     <= '0;
            y_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            d_r     <= '0;
            e_r     <= '0;
            done_q  <= 1'b0;
            product <= '0;
            valid   <= 1'b0;
        end else begin
            if (x_ld) x_r <= x_in;
            if (y_ld) y_r <= y_in;
            if (a_ld) a_r <= a_sel ? r : XW'(p);
            if (b_ld) b_r <= p;
            if (c_ld) c_r <= c_sel ? r[PW-1:0] : p;
            if (d_ld) d_r <= p;
            if (e_ld) e_r <= r[PW-1:0];
            done_q <= done;
            // Capture on the rising edge of done beats an operand reload.
            if (done && !done_q) begin
                product <= a_r;
                valid   <= 1'b1;
            end else if (x_ld || y_ld) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef KARATSUBA_FD_CHECK_EN
    logic any_ld;
    logic ld_r;
    logic ld_p;
    logic bad;

    always_comb begin
        ld_r   = (a_ld && a_sel) || (c_ld && c_sel) || e_ld;
        ld_p   = (a_ld && !a_sel) || b_ld || (c_ld && !c_sel) || d_ld
               || (ld_r && (ss_sel == SS_P0));
        any_ld = x_ld || y_ld || a_ld || b_ld || c_ld || d_ld || e_ld;
        bad    = (any_ld && ss_sel[2] && ss_sel[1])
               || ((mul_sel == MUL_NONE) && ld_p)
               || (sub && (op_a < op_b) && ld_r);
    end

    always_ff @(posedge clk) begin
        if (!rst) err <= 1'b0;
        else if (bad) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_karatsuba8_fd.sv
// Randomized self-checking bench for karatsuba8_fd against plain x*y.
module tb_karatsuba8_fd;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  x_in, y_in;
    logic        x_ld, y_ld, a_ld, b_ld, c_ld, d_ld, e_ld;
    logic        sub, a_sel, c_sel, done;
    logic [1:0]  mul_sel;
    logic [2:0]  ss_sel;
    logic [15:0] product;
    logic        valid;
`ifdef KARATSUBA_FD_CHECK_EN
    logic        err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    karatsuba8_fd #(.W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x_in),
        .y_in    (y_in),
        .x_ld    (x_ld),
        .y_ld    (y_ld),
        .a_ld    (a_ld),
        .b_ld    (b_ld),
        .c_ld    (c_ld),
        .d_ld    (d_ld),
        .e_ld    (e_ld),
        .sub     (sub),
        .a_sel   (a_sel),
        .c_sel   (c_sel),
        .done    (done),
        .mul_sel (mul_sel),
        .ss_sel  (ss_sel),
        .product (product),
        .valid   (valid)
`ifdef KARATSUBA_FD_CHECK_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        x_ld = 0; y_ld = 0; a_ld = 0; b_ld = 0; c_ld = 0;
        d_ld = 0; e_ld = 0; sub = 0; a_sel = 0; c_sel = 0;
        done = 0; mul_sel = 2'b10; ss_sel = 3'b000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load operands and walk S2..S7; stops before the done cycle.
    task automatic run_seq(input logic [7:0] x, input logic [7:0] y);
        idle(); x_in = x; y_in = y; x_ld = 1; y_ld = 1; step();
        idle(); a_ld = 1; c_ld = 1; c_sel = 1; mul_sel = 2'b00; step();
        idle(); b_ld = 1; d_ld = 1; mul_sel = 2'b01; step();
        idle(); c_ld = 1; e_ld = 1; mul_sel = 2'b11; ss_sel = 3'b010; step();
        idle(); c_ld = 1; sub = 1; c_sel = 1; ss_sel = 3'b011; step();
        idle(); a_ld = 1; a_sel = 1; ss_sel = 3'b101; step();
        idle(); a_ld = 1; a_sel = 1; ss_sel = 3'b100; step();
    endtask

    task automatic full_mul(input string tag, input logic [7:0] x,
                            input logic [7:0] y);
        logic [15:0] exp;
        exp = 16'(x) * 16'(y);
        run_seq(x, y);
        check({tag, "_vpre"}, 32'(valid), 32'd0);
        idle(); done = 1; step();
        check({tag, "_prod"}, 32'(product), 32'(exp));
        check({tag, "_valid"}, 32'(valid), 32'd1);
        idle(); step();
    endtask

    initial begin
        logic [7:0] rx, ry;
        idle();
        x_in = 0; y_in = 0; rst = 0;
        step(); step();
        check("rst_prod", 32'(product), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        rst = 1;

        full_mul("t1", 8'h12, 8'h34);
        check("t1_exact", 32'(product), 32'h03A8);

        // Operand reload drops valid but keeps the old result.
        idle(); x_in = 8'h05; x_ld = 1; step();
        check("hold_valid", 32'(valid), 32'd0);
        check("hold_prod", 32'(product), 32'h03A8);
        idle(); step(); step();
        check("hold_prod2", 32'(product), 32'h03A8);

        full_mul("t2", 8'hFF, 8'hFF);
        check("t2_exact", 32'(product), 32'hFE01);
        full_mul("t3", 8'h00, 8'hAB);

        // done held high with A changing underneath: no reload.
        full_mul("t4", 8'h9C, 8'h47);
        idle(); done = 1; step();
        idle(); done = 1; a_ld = 1; mul_sel = 2'b00; step();
        idle(); done = 1; a_ld = 1; mul_sel = 2'b11; step();
        check("frz_prod", 32'(product), 32'(16'h9C * 16'h47));
        check("frz_valid", 32'(valid), 32'd1);
        idle(); step();

        // Capture wins over a simultaneous operand load.
        run_seq(8'hC3, 8'h5A);
        idle(); done = 1; x_ld = 1; x_in = 8'h11; step();
        check("race_valid", 32'(valid), 32'd1);
        check("race_prod", 32'(product), 32'(16'hC3 * 16'h5A));
        idle(); step();

        // Reset in the middle of a sequence.
        idle(); x_in = 8'h77; y_in = 8'h88; x_ld = 1; y_ld = 1; step();
        idle(); a_ld = 1; c_ld = 1; c_sel = 1; mul_sel = 2'b00; step();
        idle(); b_ld = 1; d_ld = 1; mul_sel = 2'b01; step();
        idle(); c_ld = 1; e_ld = 1; mul_sel = 2'b11; ss_sel = 3'b010;
        rst = 0; step();
        rst = 1;
        check("mrst_prod", 32'(product), 32'd0);
        check("mrst_valid", 32'(valid), 32'd0);
        idle(); done = 1; step();
        check("mrst_a0", 32'(product), 32'd0);
        idle(); step();
        full_mul("rerun", 8'h12, 8'h34);
        check("rerun_exact", 32'(product), 32'h03A8);

        // Illegal operand select zeroes A.
        idle(); a_ld = 1; a_sel = 1; ss_sel = 3'b110; step();
        idle(); step();
        idle(); done = 1; step();
        check("ss110_prod", 32'(product), 32'd0);
`ifdef KARATSUBA_FD_CHECK_EN
        check("err_set", 32'(err), 32'd1);
        idle(); step(); step();
        check("err_sticky", 32'(err), 32'd1);
`endif
        idle(); step();

        for (int i = 0; i < 25; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            full_mul($sformatf("rnd%0d", i), rx, ry);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
